// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector (Mealy). Optional saturating match
// counter is enabled by defining SEQDET_MATCH_COUNT_EN.
module seq_detector_param #(
  parameter int unsigned    N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1001,
  parameter bit             OVERLAP = 1'b0,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 x,
  output logic                 y,
`ifdef SEQDET_MATCH_COUNT_EN
  output logic [CNT_W-1:0]     match_cnt,
`endif
  output logic [((N < 2) ? 1 : $clog2(N))-1:0] progress
);

  localparam int unsigned S_W    = (N < 2) ? 1 : $clog2(N);
  localparam int unsigned NUM_ST = 2 ** S_W;

  if (N < 2 || N > 16) begin : g_bad_n
    $error("seq_detector_param: N must be in 2..16");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("seq_detector_param: CNT_W must be at least 1");
  end

  // Next state for state s on input bit b, evaluated at elaboration (KMP automaton).
  function automatic int unsigned kmp_next(int unsigned s, int unsigned b);
    logic [16:0] seq;
    int unsigned len;
    int unsigned best;
    logic        ok;
    seq = '0;
    for (int unsigned j = 0; j < s; j++) seq[j] = PATTERN[N-1-j];
    seq[s] = b[0];
    if (seq[s] == PATTERN[N-1-s]) begin
      if (s < N - 1) return s + 1;
      if (!OVERLAP) return 0;
    end
    // Longest proper prefix of the pattern that is a suffix of the observed string.
    len  = s + 1;
    best = 0;
    for (int unsigned k = 1; k < len; k++) begin
      ok = 1'b1;
      for (int unsigned j = 0; j < k; j++)
        if (seq[len-k+j] != PATTERN[N-1-j]) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  logic [S_W-1:0] tbl [NUM_ST][2];
  logic [S_W-1:0] s;

  // Unused encodings above N-1 fall back to state 0.
  for (genvar i = 0; i < NUM_ST; i++) begin : g_st
    for (genvar b = 0; b < 2; b++) begin : g_b
      if (i < N) begin : g_valid
        assign tbl[i][b] = S_W'(kmp_next(i, b));
      end else begin : g_unused
        assign tbl[i][b] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   s <= '0;
    else if (en) s <= tbl[s][x];
  end

  assign progress = s;
  assign y        = en & ~reset & (s == S_W'(N - 1)) & (x == PATTERN[0]);

`ifdef SEQDET_MATCH_COUNT_EN
  // Saturating count of completed matches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     match_cnt <= '0;
    else if (y && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three configurations share one stimulus stream
// and are checked against a brute-force string-matching reference model.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic x;

  logic       y0, y1, y2;
  logic [1:0] p0, p1;
  logic [2:0] p2;
`ifdef SEQDET_MATCH_COUNT_EN
  logic [7:0] c0, c2;
  logic [1:0] c1;
`endif

  always #5 clk = ~clk;

  seq_detector_param #(.N(4), .PATTERN(4'b1001), .OVERLAP(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .en(en), .x(x), .y(y0),
`ifdef SEQDET_MATCH_COUNT_EN
    .match_cnt(c0),
`endif
    .progress(p0));

  seq_detector_param #(.N(4), .PATTERN(4'b1001), .OVERLAP(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .en(en), .x(x), .y(y1),
`ifdef SEQDET_MATCH_COUNT_EN
    .match_cnt(c1),
`endif
    .progress(p1));

  seq_detector_param #(.N(5), .PATTERN(5'b11011), .OVERLAP(1'b1), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset), .en(en), .x(x), .y(y2),
`ifdef SEQDET_MATCH_COUNT_EN
    .match_cnt(c2),
`endif
    .progress(p2));

  logic        ys [3];
  logic [31:0] ps [3];
  assign ys[0] = y0;
  assign ys[1] = y1;
  assign ys[2] = y2;
  assign ps[0] = 32'(p0);
  assign ps[1] = 32'(p1);
  assign ps[2] = 32'(p2);
`ifdef SEQDET_MATCH_COUNT_EN
  logic [31:0] cs [3];
  assign cs[0] = 32'(c0);
  assign cs[1] = 32'(c1);
  assign cs[2] = 32'(c2);
`endif

  // Reference configuration and state: hist holds consumed bits, newest in bit 0.
  int          nn   [3] = '{4, 4, 5};
  logic [15:0] pp   [3] = '{16'b1001, 16'b1001, 16'b11011};
  bit          ov   [3] = '{1'b0, 1'b1, 1'b1};
  int          cmax [3] = '{255, 3, 255};
  logic [15:0] hist [3];
  int          hlen [3];
  int          mcnt [3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // The last n consumed bits (including b) spell the pattern.
  function automatic logic mdl_match(int d, logic b);
    logic [15:0] w;
    logic [15:0] m;
    w = {hist[d][14:0], b};
    m = (16'h1 << nn[d]) - 16'h1;
    return (hlen[d] + 1 >= nn[d]) && ((w & m) == pp[d]);
  endfunction

  // Longest pattern prefix (shorter than n) that ends the consumed stream.
  function automatic int mdl_prog(int d);
    for (int k = nn[d] - 1; k > 0; k--)
      if (hlen[d] >= k && ((hist[d] & ((16'h1 << k) - 16'h1)) == (pp[d] >> (nn[d] - k))))
        return k;
    return 0;
  endfunction

  function automatic void mdl_reset();
    for (int d = 0; d < 3; d++) begin
      hist[d] = '0;
      hlen[d] = 0;
      mcnt[d] = 0;
    end
  endfunction

  task automatic check_all(input logic e, input logic b, output logic m [3]);
    for (int d = 0; d < 3; d++) begin
      m[d] = e && mdl_match(d, b);
      chk($sformatf("y%0d", d), 32'(ys[d]), 32'(m[d]));
      chk($sformatf("progress%0d", d), ps[d], 32'(mdl_prog(d)));
`ifdef SEQDET_MATCH_COUNT_EN
      chk($sformatf("match_cnt%0d", d), cs[d], 32'(mcnt[d]));
`endif
    end
  endtask

  task automatic step(input logic e, input logic b);
    logic m [3];
    @(negedge clk);
    en = e;
    x  = b;
    #1;
    check_all(e, b, m);
    @(posedge clk);
    if (e) begin
      for (int d = 0; d < 3; d++) begin
        if (m[d] && mcnt[d] < cmax[d]) mcnt[d]++;
        hist[d] = {hist[d][14:0], b};
        if (hlen[d] < 16) hlen[d]++;
        if (m[d] && !ov[d]) begin
          hist[d] = '0;
          hlen[d] = 0;
        end
      end
    end
  endtask

  // Reset pulse between edges with a would-be matching bit on x.
  task automatic pulse_reset();
    @(negedge clk);
    en    = 1'b1;
    x     = 1'b1;
    reset = 1'b1;
    #1;
    mdl_reset();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_y%0d", d), 32'(ys[d]), 32'd0);
      chk($sformatf("rst_progress%0d", d), ps[d], 32'd0);
`ifdef SEQDET_MATCH_COUNT_EN
      chk($sformatf("rst_cnt%0d", d), cs[d], 32'd0);
`endif
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic stream(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    x     = 1'b0;
    mdl_reset();
    repeat (2) @(posedge clk);
    pulse_reset();

    // Overlap/non-overlap comparison: 1,0,0,1,0,0,1.
    stream(16'b1001001, 7);
    pulse_reset();
    // KMP fallback keeps one matched bit: 1,1,0,0,1.
    stream(16'b11001, 5);
    pulse_reset();
    // Enable gating mid-pattern.
    stream(16'b10, 2);
    repeat (3) step(1'b0, 1'b1);
    stream(16'b01, 2);
    pulse_reset();
    // Reset discards partial progress.
    stream(16'b100, 3);
    pulse_reset();
    stream(16'b1001, 4);
    pulse_reset();
    // Long overlapping run drives the 2-bit counter into saturation.
    stream(16'b1001001001001, 13);
    stream(16'b11011011, 8);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
